mbscore_fetch: RTL and testbench
================================

Name: mbscore_fetch

Overview:
Instruction fetch unit feeding the core controller. It owns the PC and the instruction register (IR). On the controller's IF strobe it issues a variable-latency bus read at PC and latches the returned word into IR. It drives `inst` to the controller and decoder, and reports busy and fault status so the controller can hold in IF.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, max cycles to wait for bus_ack before a fetch fault (range 2..65535).

Ports:
clk  in  1  core clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
ir_ack  in  1  fetch strobe from controller (IF state)
hlt  in  1  halt request from controller
pc_load  in  1  load PC from pc_target (jump/branch/JR resolved)
pc_target  in  32  next PC when pc_load=1
bus_addr  out  32  fetch address to bus
bus_re  out  1  bus read request, level, held until ack
bus_rdata  in  32  bus read data, valid when bus_ack=1
bus_ack  in  1  bus read completion
inst  out  32  instruction register
pc  out  32  current PC register
pc_plus4  out  32  combinational pc+4, used for JAL link
fetch_busy  out  1  fetch in flight; controller must stay in IF
inst_valid  out  1  one-cycle pulse when IR updated
fetch_fault  out  1  sticky fault flag
fault_code  out  2  00 none, 01 misaligned PC, 10 bus timeout

Behaviour:
- Synchronous active-high reset; every output and state register updates only on the rising edge of clk.
- Reset values: pc=RESET_PC; inst=0 (NOP); bus_addr=0; bus_re=0; fetch_busy=0; inst_valid=0; fetch_fault=0; fault_code=00; state=IDLE; wait timer=0; pending-load flag clear.
- rst overrides everything, including a fetch in flight. A bus_ack arriving after reset is ignored.
- States: IDLE, WAIT, HALT, FAULT.
- IDLE, entry priority (highest first):
  - hlt=1 -> HALT.
  - ir_ack=1 with pc[1:0]!=0 -> FAULT, fault_code=01, no bus request.
  - ir_ack=1 (aligned) -> WAIT. Next cycle: bus_addr=pc, bus_re=1, fetch_busy=1, timer=0.
  - Otherwise stay in IDLE.
- pc_load=1 in IDLE: pc<=pc_target that cycle. If ir_ack is also high in the same cycle, the fetch uses the OLD pc and the load is recorded as pending.
- WAIT:
  - bus_re and bus_addr are held stable until bus_ack is sampled high.
  - On bus_ack: inst<=bus_rdata, bus_re<=0, fetch_busy<=0, inst_valid=1 for exactly one cycle, return to IDLE (to HALT if hlt was seen during WAIT).
  - PC update on completion: pending target if a pc_load occurred at any time during WAIT (the last target wins), else pc+4.
  - PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- Latency: ir_ack sampled at edge N -> bus_re high after edge N. bus_ack sampled at edge M -> inst and inst_valid updated after edge M. Minimum fetch is 2 cycles from ir_ack to inst_valid.
- Timeout:
  - The timer increments each WAIT cycle without bus_ack.
  - When the timer reaches TIMEOUT-1 with bus_ack still low -> FAULT, fault_code=10, bus_re<=0, inst<=0, fetch_busy<=0.
  - bus_ack in that same final cycle wins over the timeout.
- ir_ack while in WAIT, HALT or FAULT is ignored.
- bus_ack outside WAIT is ignored.
- hlt in WAIT is recorded and takes effect after completion; it never aborts a bus transaction.
- HALT: bus_re=0, pc and inst frozen, pc_load ignored; left only by rst.
- FAULT: fetch_fault=1 and fault_code held; no bus requests; pc frozen at the faulting address; left only by rst.
- inst holds its last value between fetches. The controller decodes from the stable IR across ID/EXE/WB.

Test Plan:
- Zero-wait fetch: reset with RESET_PC=0, ir_ack pulse, bus_ack the same cycle bus_re rises with rdata=32'h2008_0005 -> bus_addr=0, inst=32'h2008_0005, one inst_valid pulse, pc=4, pc_plus4=8.
- 3-wait fetch: bus_ack delayed 3 cycles after bus_re -> bus_re and bus_addr stable for 4 cycles, fetch_busy high throughout, inst updated exactly one cycle after ack, pc advances by 4.
- pc_load mid-fetch: pc=0x10, ir_ack, then pc_load with target 0x40 during WAIT, ack with rdata=0x0800_0010 -> inst=0x0800_0010 and pc=0x40 (not 0x14); the next fetch's bus_addr=0x40.
- Misaligned: pc_load target 0x42 in IDLE, then ir_ack -> no bus_re, fetch_fault=1, fault_code=01, pc=0x42; further ir_ack has no effect until rst.
- Timeout: TIMEOUT=16, bus_ack never asserted -> bus_re drops after 16 WAIT cycles, fault_code=10, inst=0. A second run with ack on the 16th cycle -> normal completion, no fault.
- Halt and reset mid-fetch: hlt during WAIT, then ack -> one fetch completes and the state becomes HALT, with later ir_ack and pc_load ignored. Separately, rst asserted during WAIT -> pc=RESET_PC, bus_re=0, and a late bus_ack leaves inst=0.

Source files
------------

// File: rtl/mbscore_fetch_if.sv
// Instruction-fetch bus: a level read request held until the responder
// acknowledges it with data.
interface mbscore_fetch_if;
  logic [31:0] bus_addr;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (output bus_addr, output bus_re, input bus_rdata, input bus_ack);
  modport slave  (input bus_addr, input bus_re, output bus_rdata, output bus_ack);
endinterface

// File: rtl/mbscore_fetch.sv
// Instruction fetch unit: owns PC and IR, issues variable-latency bus reads on
// the controller's IF strobe, and reports busy/fault status back to it.
module mbscore_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ir_ack,
  input  logic                   hlt,
  input  logic                   pc_load,
  input  logic [31:0]            pc_target,
  mbscore_fetch_if.master        bus,
  output logic [31:0]            inst,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic                   fetch_busy,
  output logic                   inst_valid,
  output logic                   fetch_fault,
  output logic [1:0]             fault_code
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALT, S_FAULT} state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic        bus_re_q, bus_re_d;
  logic        fetch_busy_q, fetch_busy_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [15:0] timer_q, timer_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        hlt_seen_q, hlt_seen_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    bus_addr_d    = bus_addr_q;
    bus_re_d      = bus_re_q;
    fetch_busy_d  = fetch_busy_q;
    inst_valid_d  = 1'b0;
    fetch_fault_d = fetch_fault_q;
    fault_code_d  = fault_code_q;
    timer_d       = timer_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    hlt_seen_d    = hlt_seen_q;

    unique case (state_q)
      S_IDLE: begin
        if (hlt) begin
          state_d = S_HALT;
        end else if (ir_ack && (pc_q[1:0] != 2'b00)) begin
          state_d       = S_FAULT;
          fetch_fault_d = 1'b1;
          fault_code_d  = 2'b01;
        end else begin
          if (pc_load) pc_d = pc_target;
          if (ir_ack) begin
            // Fetch uses the old PC; a simultaneous load is replayed at completion.
            state_d       = S_WAIT;
            bus_addr_d    = pc_q;
            bus_re_d      = 1'b1;
            fetch_busy_d  = 1'b1;
            timer_d       = '0;
            pend_d        = pc_load;
            pend_target_d = pc_target;
            hlt_seen_d    = 1'b0;
          end
        end
      end

      S_WAIT: begin
        if (pc_load) begin
          pend_d        = 1'b1;
          pend_target_d = pc_target;
        end
        if (hlt) hlt_seen_d = 1'b1;

        if (bus.bus_ack) begin
          inst_d       = bus.bus_rdata;
          bus_re_d     = 1'b0;
          fetch_busy_d = 1'b0;
          inst_valid_d = 1'b1;
          pend_d       = 1'b0;
          if (pc_load)     pc_d = pc_target;
          else if (pend_q) pc_d = pend_target_q;
          else             pc_d = pc_q + 32'd4;
          state_d = (hlt_seen_q || hlt) ? S_HALT : S_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          state_d       = S_FAULT;
          fetch_fault_d = 1'b1;
          fault_code_d  = 2'b10;
          bus_re_d      = 1'b0;
          inst_d        = '0;
          fetch_busy_d  = 1'b0;
          pend_d        = 1'b0;
          pc_d          = bus_addr_q;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      S_HALT, S_FAULT: ;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inst_q        <= '0;
      bus_addr_q    <= '0;
      bus_re_q      <= 1'b0;
      fetch_busy_q  <= 1'b0;
      inst_valid_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
      fault_code_q  <= 2'b00;
      timer_q       <= '0;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
      hlt_seen_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      bus_addr_q    <= bus_addr_d;
      bus_re_q      <= bus_re_d;
      fetch_busy_q  <= fetch_busy_d;
      inst_valid_q  <= inst_valid_d;
      fetch_fault_q <= fetch_fault_d;
      fault_code_q  <= fault_code_d;
      timer_q       <= timer_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      hlt_seen_q    <= hlt_seen_d;
    end
  end

  assign bus.bus_addr = bus_addr_q;
  assign bus.bus_re   = bus_re_q;
  assign inst         = inst_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign fetch_busy   = fetch_busy_q;
  assign inst_valid   = inst_valid_q;
  assign fetch_fault  = fetch_fault_q;
  assign fault_code   = fault_code_q;

endmodule

// File: tb/tb_mbscore_fetch.sv
// Directed bench for mbscore_fetch with hand-computed expectations per scenario.
module tb_mbscore_fetch;
  logic        clk = 1'b0;
  logic        rst, ir_ack, hlt, pc_load;
  logic [31:0] pc_target;
  logic [31:0] inst, pc, pc_plus4;
  logic        fetch_busy, inst_valid, fetch_fault;
  logic [1:0]  fault_code;
  int          checks = 0;
  int          errors = 0;

  mbscore_fetch_if bus_if ();

  mbscore_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .ir_ack(ir_ack), .hlt(hlt), .pc_load(pc_load),
    .pc_target(pc_target), .bus(bus_if.master), .inst(inst), .pc(pc),
    .pc_plus4(pc_plus4), .fetch_busy(fetch_busy), .inst_valid(inst_valid),
    .fetch_fault(fetch_fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ir_ack = 1'b0; hlt = 1'b0; pc_load = 1'b0; pc_target = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want %h", pc, 32'h0); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL rst_pc_plus4: got %h want %h", pc_plus4, 32'h4); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h want %h", inst, 32'h0); end
    checks++; if (bus_if.bus_addr !== 32'h0) begin errors++; $display("FAIL rst_bus_addr: got %h want %h", bus_if.bus_addr, 32'h0); end
    checks++; if ({bus_if.bus_re, fetch_busy, inst_valid, fetch_fault} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want %b", {bus_if.bus_re, fetch_busy, inst_valid, fetch_fault}, 4'b0000); end
    checks++; if (fault_code !== 2'b00) begin errors++; $display("FAIL rst_fault_code: got %b want %b", fault_code, 2'b00); end
  endtask

  task automatic test_zero_wait();
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    checks++; if (bus_if.bus_re !== 1'b1 || fetch_busy !== 1'b1) begin errors++; $display("FAIL zw_req: got re=%b busy=%b want 1 1", bus_if.bus_re, fetch_busy); end
    checks++; if (bus_if.bus_addr !== 32'h0) begin errors++; $display("FAIL zw_addr: got %h want %h", bus_if.bus_addr, 32'h0); end
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h2008_0005; tick(); bus_if.bus_ack = 1'b0;
    checks++; if (inst !== 32'h2008_0005) begin errors++; $display("FAIL zw_inst: got %h want %h", inst, 32'h2008_0005); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL zw_valid: got %b want 1", inst_valid); end
    checks++; if (pc !== 32'h4 || pc_plus4 !== 32'h8) begin errors++; $display("FAIL zw_pc: got %h/%h want 4/8", pc, pc_plus4); end
    checks++; if (bus_if.bus_re !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL zw_done: got re=%b busy=%b want 0 0", bus_if.bus_re, fetch_busy); end
    tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL zw_pulse: got %b want 0", inst_valid); end
    checks++; if (inst !== 32'h2008_0005) begin errors++; $display("FAIL zw_hold: got %h want %h", inst, 32'h2008_0005); end
  endtask

  task automatic test_three_wait();
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hAABB_CC01; end
      checks++; if (bus_if.bus_re !== 1'b1 || bus_if.bus_addr !== 32'h4 || fetch_busy !== 1'b1 || inst_valid !== 1'b0) begin
        errors++; $display("FAIL w3_hold%0d: got re=%b addr=%h busy=%b v=%b want 1 4 1 0", i, bus_if.bus_re, bus_if.bus_addr, fetch_busy, inst_valid); end
      if (i < 3) tick();
    end
    tick(); bus_if.bus_ack = 1'b0;
    checks++; if (inst !== 32'hAABB_CC01 || inst_valid !== 1'b1) begin errors++; $display("FAIL w3_inst: got %h v=%b want aabbcc01 1", inst, inst_valid); end
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL w3_pc: got %h want %h", pc, 32'h8); end
  endtask

  task automatic test_pc_load_mid();
    pc_load = 1'b1; pc_target = 32'h10; tick(); pc_load = 1'b0;
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL pl_idle: got %h want %h", pc, 32'h10); end
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    checks++; if (bus_if.bus_addr !== 32'h10) begin errors++; $display("FAIL pl_addr: got %h want %h", bus_if.bus_addr, 32'h10); end
    pc_load = 1'b1; pc_target = 32'h40; tick(); pc_load = 1'b0;
    checks++; if (bus_if.bus_addr !== 32'h10 || bus_if.bus_re !== 1'b1) begin errors++; $display("FAIL pl_stable: got %h re=%b want 10 1", bus_if.bus_addr, bus_if.bus_re); end
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h0800_0010; tick(); bus_if.bus_ack = 1'b0;
    checks++; if (inst !== 32'h0800_0010 || pc !== 32'h40) begin errors++; $display("FAIL pl_done: got inst=%h pc=%h want 08000010 40", inst, pc); end
    // next fetch at 0x40; two loads during WAIT, last (0x90) wins, arriving with the ack
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    checks++; if (bus_if.bus_addr !== 32'h40) begin errors++; $display("FAIL pl_next_addr: got %h want %h", bus_if.bus_addr, 32'h40); end
    pc_load = 1'b1; pc_target = 32'h80; tick();
    pc_target = 32'h90; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1111_2222; tick();
    pc_load = 1'b0; bus_if.bus_ack = 1'b0;
    checks++; if (pc !== 32'h90) begin errors++; $display("FAIL pl_last_wins: got %h want %h", pc, 32'h90); end
    // load together with ir_ack in IDLE: fetch old pc, complete to the target
    ir_ack = 1'b1; pc_load = 1'b1; pc_target = 32'h100; tick(); ir_ack = 1'b0; pc_load = 1'b0;
    checks++; if (bus_if.bus_addr !== 32'h90) begin errors++; $display("FAIL pl_same_addr: got %h want %h", bus_if.bus_addr, 32'h90); end
    bus_if.bus_ack = 1'b1; tick(); bus_if.bus_ack = 1'b0;
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL pl_same_pc: got %h want %h", pc, 32'h100); end
  endtask

  task automatic test_wrap();
    pc_load = 1'b1; pc_target = 32'hFFFF_FFFC; tick(); pc_load = 1'b0;
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h want %h", pc_plus4, 32'h0); end
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h0000_0777; tick(); bus_if.bus_ack = 1'b0;
    checks++; if (pc !== 32'h0 || inst !== 32'h0000_0777) begin errors++; $display("FAIL wrap_pc: got pc=%h inst=%h want 0 777", pc, inst); end
  endtask

  task automatic test_timeout();
    int cycles;
    // ack on the 16th WAIT cycle still completes
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (bus_if.bus_re !== 1'b1) begin errors++; $display("FAIL to_last_re: got %b want 1", bus_if.bus_re); end
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h0BAD_F00D; tick(); bus_if.bus_ack = 1'b0;
    checks++; if (inst_valid !== 1'b1 || fetch_fault !== 1'b0 || inst !== 32'h0BAD_F00D || pc !== 32'h4) begin
      errors++; $display("FAIL to_late_ack: got v=%b f=%b inst=%h pc=%h want 1 0 0badf00d 4", inst_valid, fetch_fault, inst, pc); end
    // no ack at all
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    cycles = 0;
    while (bus_if.bus_re === 1'b1 && cycles < 40) begin cycles++; tick(); end
    checks++; if (cycles != 16) begin errors++; $display("FAIL to_cycles: got %0d want %0d", cycles, 16); end
    checks++; if (fetch_fault !== 1'b1 || fault_code !== 2'b10) begin errors++; $display("FAIL to_code: got f=%b code=%b want 1 10", fetch_fault, fault_code); end
    checks++; if (inst !== 32'h0 || fetch_busy !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h4) begin
      errors++; $display("FAIL to_state: got inst=%h busy=%b v=%b pc=%h want 0 0 0 4", inst, fetch_busy, inst_valid, pc); end
    ir_ack = 1'b1; tick(); tick(); ir_ack = 1'b0;
    checks++; if (bus_if.bus_re !== 1'b0 || fault_code !== 2'b10) begin errors++; $display("FAIL to_sticky: got re=%b code=%b want 0 10", bus_if.bus_re, fault_code); end
  endtask

  task automatic test_misaligned();
    do_reset();
    pc_load = 1'b1; pc_target = 32'h42; tick(); pc_load = 1'b0;
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    checks++; if (bus_if.bus_re !== 1'b0 || fetch_fault !== 1'b1 || fault_code !== 2'b01) begin
      errors++; $display("FAIL mis_fault: got re=%b f=%b code=%b want 0 1 01", bus_if.bus_re, fetch_fault, fault_code); end
    checks++; if (pc !== 32'h42) begin errors++; $display("FAIL mis_pc: got %h want %h", pc, 32'h42); end
    ir_ack = 1'b1; pc_load = 1'b1; pc_target = 32'h80; tick(); tick(); ir_ack = 1'b0; pc_load = 1'b0;
    checks++; if (bus_if.bus_re !== 1'b0 || pc !== 32'h42 || fault_code !== 2'b01) begin
      errors++; $display("FAIL mis_sticky: got re=%b pc=%h code=%b want 0 42 01", bus_if.bus_re, pc, fault_code); end
  endtask

  task automatic test_halt();
    do_reset();
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    hlt = 1'b1; tick(); hlt = 1'b0;
    checks++; if (bus_if.bus_re !== 1'b1) begin errors++; $display("FAIL hlt_no_abort: got %b want 1", bus_if.bus_re); end
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h3C01_1234; tick(); bus_if.bus_ack = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h3C01_1234 || pc !== 32'h4) begin
      errors++; $display("FAIL hlt_complete: got v=%b inst=%h pc=%h want 1 3c011234 4", inst_valid, inst, pc); end
    ir_ack = 1'b1; pc_load = 1'b1; pc_target = 32'h200; tick(); tick(); ir_ack = 1'b0; pc_load = 1'b0;
    checks++; if (bus_if.bus_re !== 1'b0 || pc !== 32'h4 || inst !== 32'h3C01_1234 || fetch_fault !== 1'b0) begin
      errors++; $display("FAIL hlt_frozen: got re=%b pc=%h inst=%h f=%b want 0 4 3c011234 0", bus_if.bus_re, pc, inst, fetch_fault); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    pc_load = 1'b1; pc_target = 32'h20; tick(); pc_load = 1'b0;
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (pc !== 32'h0 || bus_if.bus_re !== 1'b0 || fetch_busy !== 1'b0) begin
      errors++; $display("FAIL rmid_reset: got pc=%h re=%b busy=%b want 0 0 0", pc, bus_if.bus_re, fetch_busy); end
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF; tick(); bus_if.bus_ack = 1'b0;
    checks++; if (inst !== 32'h0 || inst_valid !== 1'b0 || pc !== 32'h0) begin
      errors++; $display("FAIL rmid_late_ack: got inst=%h v=%b pc=%h want 0 0 0", inst, inst_valid, pc); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_three_wait();
    test_pc_load_mid();
    test_wrap();
    test_timeout();
    test_misaligned();
    test_halt();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
